multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core variant. It sequences one shared ALU, one unified instruction/data memory port, the register file and the PC/IR/OldPC/ALUOut holding registers. Each instruction takes 3–5 states, with a stall handshake on the memory port. It covers the same instruction subset as the single-cycle decoder: R-ALU, I-ALU, loads, stores, beq/bne, jal and jalr.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (passed through to the package; not used for control logic).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- op  in  7  opcode from the IR.
- funct3  in  3  funct3 from the IR.
- funct7  in  7  funct7 from the IR.
- zero  in  1  ALU zero flag for the current cycle.
- mem_ready  in  1  memory accepted/returned the access this cycle.
- pc_write  out  1  PC ← result bus.
- ir_write  out  1  IR ← read data; OldPC ← PC.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- reg_write  out  1  register file write of the result bus.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A.
- alu_src_b  out  2  00 = rs2 register B, 01 = ImmExt, 10 = constant 4.
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 1000 srl, 1011 sra, 1101 sll.
- result_src  out  2  00 = ALUOut, 01 = Data register, 10 = ALU result.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J.
- addressing_control  out  3  funct3 during memory states, else 000.
- instr_done  out  1  one-cycle pulse in the retiring cycle.
- illegal  out  1  sticky; set on an unsupported encoding.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, JALR_PC, TRAP.
- Outputs are a Moore decode of the state, gated by mem_ready and zero. Unlisted outputs are 0.
- FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - If mem_ready: ir_write=1 and pc_write=1, then go to DECODE.
  - Otherwise hold in FETCH with both strobes 0.
- DECODE: alu_src_a=01, alu_src_b=01, add, producing ALUOut = OldPC+imm.
  - imm_src is 010 for op 1100011, 011 for op 1101111, else 000.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR.
    - any other op → TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src is 000 for loads and 001 for stores. Next state is MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_read=1, adr_src=1. Go to MEMWB on mem_ready, else hold.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- MEMWRITE: mem_write=1, adr_src=1. On mem_ready: instr_done=1, then FETCH; else hold.
- EXEC_R: operands A/B.
  - funct3/funct7 decode: 000/0000000 add, 000/0100000 sub, 100 xor, 110 or, 111 and, 101/0000000 srl, 101/0100000 sra.
  - Any other combination → TRAP.
- EXEC_I: operands A/ImmExt. funct3 000 add, 001 sll, 100 xor, 110 or, 111 and, 101 srl or sra selected by funct7. Else → TRAP.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = zero for funct3 000 (beq) and !zero for funct3 001 (bne).
  - instr_done=1, then FETCH.
  - Any other funct3 → TRAP with pc_write=0.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Then ALUWB writes rd = OldPC+4.
- JALR: alu_src_a=01, alu_src_b=10, add, result_src=10, reg_write=1 (rd ← OldPC+4), then JALR_PC.
- JALR_PC: alu_src_a=10, alu_src_b=01, imm_src=000, add, result_src=10, pc_write=1, instr_done=1, then FETCH.
  - Register A was latched in DECODE, so rd == rs1 is safe.
- TRAP: all strobes 0, illegal=1. Only rst leaves TRAP.

## Timing
- Reset: on a rst-high edge, state←FETCH and illegal←0. While rst is high, pc_write, ir_write, mem_read, mem_write, reg_write and instr_done are forced to 0.
  - rst mid-instruction aborts it; nothing is written in the reset cycle.
- Latency with mem_ready tied to 1:
  - branch: 3 cycles.
  - R, I, store, jal, jalr: 4 cycles.
  - load: 5 cycles.
  - Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake:
  - mem_read/mem_write stay asserted, with a stable adr_src, until the cycle in which mem_ready=1.
  - mem_ready is ignored in all other states.
- instr_done is exactly one cycle per retired instruction. It never asserts in TRAP.
- zero is sampled combinationally in BRANCH only.

## Structure
- Package multicycle_pkg holds:
  - the state enum `mc_state_t`;
  - opcode constants;
  - the ALU_* alu_control encodings;
  - the IMM_* imm_src encodings;
  - the SRCA_*, SRCB_* and RES_* mux encodings.
- One sub-module, `mc_alu_decoder`: a combinational map of (state, funct3, funct7) → alu_control plus a `bad` flag. It is used by EXEC_R and EXEC_I.

## Test plan
- add x3,x1,x2 with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALUWB; alu_control=0001 only for funct7=0100000; instr_done pulses in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → mem_read and adr_src=1 held for 3 cycles; MEMWB fires on cycle 7 with result_src=01.
- beq with zero=1 → pc_write=1 in BRANCH; bne with zero=1 → pc_write=0; both retire in cycle 3.
- jalr x1,0(x1) → JALR asserts reg_write with result_src=10; JALR_PC asserts pc_write with alu_src_a=10; 4 cycles total.
- op=0110111 → TRAP; illegal=1 from the next cycle; no strobes for 10 cycles; rst → FETCH and illegal=0.
- rst asserted in MEMWRITE with mem_ready=1 → mem_write=0 in that cycle; FETCH next cycle.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// States, opcodes and datapath mux/ALU select codes live here.
package multicycle_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_TRAP
    } mc_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1011;
    localparam logic [3:0] ALU_SLL = 4'b1101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation select for the execute states; flags encodings
// that the core does not implement so the FSM can trap.
module mc_alu_decoder
    import multicycle_pkg::*;
(
    input  mc_state_t  state,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic       bad
);

    logic is_r;
    logic is_i;

    assign is_r = (state == S_EXEC_R);
    assign is_i = (state == S_EXEC_I);

    always_comb begin
        alu_control = ALU_ADD;
        bad         = 1'b0;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: begin
                    if (is_r && funct7 == F7_ALT)
                        alu_control = ALU_SUB;
                    else if (is_r && funct7 != F7_BASE)
                        bad = 1'b1;
                end
                3'b001: begin
                    alu_control = ALU_SLL;
                    bad         = is_r;
                end
                3'b100: alu_control = ALU_XOR;
                3'b110: alu_control = ALU_OR;
                3'b111: alu_control = ALU_AND;
                3'b101: begin
                    if (funct7 == F7_ALT)
                        alu_control = ALU_SRA;
                    else if (funct7 == F7_BASE)
                        alu_control = ALU_SRL;
                    else
                        bad = 1'b1;
                end
                default: bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences the shared
// ALU, unified memory port, register file and holding registers.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [2:0] addressing_control,
    output logic       instr_done,
    output logic       illegal
);

    if (DATA_WIDTH != XLEN) begin : g_nonstd_width
    end

    mc_state_t  state;
    mc_state_t  state_next;
    logic       illegal_q;
    logic [3:0] dec_alu;
    logic       dec_bad;
    logic       pc_w, ir_w, mr, mw, rw, done;

    mc_alu_decoder u_alu_dec (
        .state       (state),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu),
        .bad         (dec_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_next         = state;
        pc_w               = 1'b0;
        ir_w               = 1'b0;
        mr                 = 1'b0;
        mw                 = 1'b0;
        rw                 = 1'b0;
        done               = 1'b0;
        adr_src            = 1'b0;
        alu_src_a          = SRCA_PC;
        alu_src_b          = SRCB_REGB;
        alu_control        = ALU_ADD;
        result_src         = RES_ALUOUT;
        imm_src            = IMM_I;
        addressing_control = 3'b000;
        unique case (state)
            S_FETCH: begin
                mr         = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_w       = 1'b1;
                    pc_w       = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (op == OP_BRANCH)
                    imm_src = IMM_B;
                else if (op == OP_JAL)
                    imm_src = IMM_J;
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_next = S_MEMADR;
                    OP_R:      state_next = S_EXEC_R;
                    OP_I:      state_next = S_EXEC_I;
                    OP_BRANCH: state_next = S_BRANCH;
                    OP_JAL:    state_next = S_JAL;
                    OP_JALR:   state_next = S_JALR;
                    default:   state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a          = SRCA_REGA;
                alu_src_b          = SRCB_IMM;
                addressing_control = funct3;
                imm_src    = (op == OP_STORE) ? IMM_S : IMM_I;
                state_next = (op == OP_STORE) ? S_MEMWRITE
                                              : S_MEMREAD;
            end
            S_MEMREAD: begin
                mr                 = 1'b1;
                adr_src            = 1'b1;
                addressing_control = funct3;
                if (mem_ready)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src         = RES_DATA;
                rw                 = 1'b1;
                done               = 1'b1;
                addressing_control = funct3;
                state_next         = S_FETCH;
            end
            S_MEMWRITE: begin
                mw                 = 1'b1;
                adr_src            = 1'b1;
                addressing_control = funct3;
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a   = SRCA_REGA;
                alu_src_b   = (state == S_EXEC_I) ? SRCB_IMM
                                                  : SRCB_REGB;
                alu_control = dec_alu;
                state_next  = dec_bad ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                rw         = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_REGA;
                alu_control = ALU_SUB;
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    // bne takes the branch on a non-zero difference
                    pc_w       = zero ^ funct3[0];
                    done       = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_w       = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                rw         = 1'b1;
                state_next = S_JALR_PC;
            end
            S_JALR_PC: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_w       = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
    end

    assign pc_write   = pc_w & ~rst;
    assign ir_write   = ir_w & ~rst;
    assign mem_read   = mr & ~rst;
    assign mem_write  = mw & ~rst;
    assign reg_write  = rw & ~rst;
    assign instr_done = done & ~rst;
    assign illegal    = illegal_q;

endmodule
